// File: rtl/prog_ram.sv
// prog_ram: 16x8 program RAM. A byte-stream loader fills it, then the CPU takes over.
// Optional LOAD_CHECKSUM_EN: a trailing checksum byte gates the hand-off (adds CHECK/ERR).
module prog_ram (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_we,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       start,
    output logic       load_done,
    output logic       load_err,
    output logic [4:0] ld_count
);

`ifdef LOAD_CHECKSUM_EN
    typedef enum logic [1:0] {LOAD, CHECK, RUN, ERR} state_t;
`else
    typedef enum logic [0:0] {LOAD, RUN} state_t;
`endif

    state_t     state_q;
    logic [7:0] mem_q [16];
    logic [3:0] wptr_q;
    logic [4:0] ld_count_q;
    logic       ld_ready_q;
    logic       start_q;
    logic       load_done_q;

    logic       accept;
    logic       load_end;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    assign accept   = ld_valid & ld_ready_q;
    // The write to address 15 ends the load even without ld_last, so wptr never wraps.
    assign load_end = ld_last | (wptr_q == 4'hF);

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       load_err_q;
    logic [7:0] chk_total;

    assign chk_total = sum_q + ld_data;
    assign load_err  = load_err_q;
`else
    assign load_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= LOAD;
            wptr_q      <= 4'h0;
            ld_count_q  <= 5'd0;
            ld_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            load_done_q <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            sum_q       <= 8'h00;
            load_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (wptr_q != 4'hF) wptr_q <= wptr_q + 4'd1;
                        if (ld_count_q != 5'd16) ld_count_q <= ld_count_q + 5'd1;
`ifdef LOAD_CHECKSUM_EN
                        sum_q <= sum_q + ld_data;
                        if (load_end) state_q <= CHECK;
`else
                        if (load_end) begin
                            state_q     <= RUN;
                            ld_ready_q  <= 1'b0;
                            start_q     <= 1'b1;
                            load_done_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOAD_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        ld_ready_q <= 1'b0;
                        if (chk_total == 8'h00) begin
                            state_q     <= RUN;
                            start_q     <= 1'b1;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: ;  // RUN and ERR are held until reset
            endcase
        end
    end

    // Single write port: loader in LOAD, CPU in RUN; the checksum byte is never stored.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wptr_q;
        wr_data = ld_data;
        if (state_q == LOAD) begin
            wr_en = accept;
        end else if ((state_q == RUN) && cpu_we) begin
            wr_en   = 1'b1;
            wr_addr = cpu_addr;
            wr_data = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cpu_rdata = mem_q[cpu_addr];
    assign ld_ready  = ld_ready_q;
    assign start     = start_q;
    assign load_done = load_done_q;
    assign ld_count  = ld_count_q;

endmodule

// File: tb/tb_prog_ram.sv
// Self-checking bench for prog_ram: randomized loads and CPU traffic against a byte-list model.
// Checksum scenarios are exercised when LOAD_CHECKSUM_EN is defined.
module tb_prog_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [3:0] cpu_addr;
    logic       cpu_we;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       start;
    logic       load_done;
    logic       load_err;
    logic [4:0] ld_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected RAM image and number of program bytes the current load should leave behind.
    logic [7:0] exp_mem [16];
    int         exp_k;

    prog_ram dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .start     (start),
        .load_done (load_done),
        .load_err  (load_err),
        .ld_count  (ld_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 4'h0;
        cpu_wdata = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = l;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Idle loader cycles with ld_last noise that must never count.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b0;
            ld_last  = 1'($urandom);
            ld_data  = 8'($urandom);
            step();
        end
        ld_last = 1'b0;
    endtask

    // Sends the correct checksum for exp_mem[0..exp_k-1] when the checksum stage exists.
    task automatic finish_load();
`ifdef LOAD_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < exp_k; i++) s = s + exp_mem[i];
        send_byte(~s + 8'd1, 1'b0);
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        ld_valid  = 1'b1;
        ld_data   = 8'h77;
        cpu_we    = 1'b1;
        cpu_addr  = 4'h3;
        cpu_wdata = 8'h99;
        reset     = 1'b0;
        step();
        reset = 1'b1;
        idle_inputs();
        #1;
        n_tests++;
        if (ld_ready !== 1'b1 || start !== 1'b0 || load_done !== 1'b0 ||
            load_err !== 1'b0 || ld_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ld_ready=%b start=%b load_done=%b load_err=%b ld_count=%0d, want 1 0 0 0 0",
                     ld_ready, start, load_done, load_err, ld_count);
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cpu_addr = 4'(a);
            #1;
            n_tests++;
            if (cpu_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mem[%0d]: got %h want 00", a, cpu_rdata);
            end
        end
    endtask

    task automatic test_full_load();
        do_reset();
        exp_k = 16;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(8'h10 + i);
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (ld_ready !== 1'b1 || start !== 1'b0) begin
                n_fail++;
                $display("FAIL full_pre[%0d]: ld_ready=%b start=%b want 1 0", i, ld_ready, start);
            end
            send_byte(exp_mem[i], 1'b0);
            n_tests++;
            if (ld_count !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL full_count[%0d]: got %0d want %0d", i, ld_count, i + 1);
            end
        end
        finish_load();
        n_tests++;
        if (start !== 1'b1 || load_done !== 1'b1 || ld_ready !== 1'b0 ||
            load_err !== 1'b0 || ld_count !== 5'd16) begin
            n_fail++;
            $display("FAIL full_run: start=%b load_done=%b ld_ready=%b load_err=%b ld_count=%0d, want 1 1 0 0 16",
                     start, load_done, ld_ready, load_err, ld_count);
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cpu_addr = 4'(a);
            #1;
            n_tests++;
            if (cpu_rdata !== exp_mem[a]) begin
                n_fail++;
                $display("FAIL full_mem[%0d]: got %h want %h", a, cpu_rdata, exp_mem[a]);
            end
        end
        step();
        send_byte(8'hEE, 1'b1);
        cpu_addr = 4'h0;
        #1;
        n_tests++;
        if (ld_count !== 5'd16 || cpu_rdata !== 8'h10 || start !== 1'b1) begin
            n_fail++;
            $display("FAIL full_extra_byte: ld_count=%0d mem0=%h start=%b want 16 10 1", ld_count, cpu_rdata, start);
        end
    endtask

    task automatic test_random_load();
        for (int t = 0; t < 6; t++) begin
            int lastpos;
            do_reset();
            lastpos = int'($urandom_range(0, 23));
            exp_k   = (lastpos < 16) ? lastpos + 1 : 16;
            for (int i = 0; i < 16; i++) exp_mem[i] = (i < exp_k) ? 8'($urandom) : 8'h00;
            for (int i = 0; i < exp_k; i++) begin
                gap(int'($urandom_range(0, 2)));
                if (i == exp_k - 1) begin
                    n_tests++;
                    if (ld_count !== 5'(exp_k - 1) || start !== 1'b0 || ld_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rand_pre_last[%0d]: ld_count=%0d start=%b ld_ready=%b want %0d 0 1",
                                 t, ld_count, start, ld_ready, exp_k - 1);
                    end
                end
                send_byte(exp_mem[i], (i == lastpos));
            end
            finish_load();
            n_tests++;
            if (start !== 1'b1 || load_done !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 5'(exp_k)) begin
                n_fail++;
                $display("FAIL rand_run[%0d]: start=%b load_done=%b ld_ready=%b ld_count=%0d want 1 1 0 %0d",
                         t, start, load_done, ld_ready, ld_count, exp_k);
            end
            for (int a = 0; a < 16; a++) begin
                @(negedge clk);
                cpu_addr = 4'(a);
                #1;
                n_tests++;
                if (cpu_rdata !== exp_mem[a]) begin
                    n_fail++;
                    $display("FAIL rand_mem[%0d][%0d]: got %h want %h", t, a, cpu_rdata, exp_mem[a]);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        step();
        cpu_addr  = 4'hF;
        cpu_we    = 1'b1;
        cpu_wdata = 8'hA5;
        #1;
        n_tests++;
        if (cpu_rdata !== exp_mem[15]) begin
            n_fail++;
            $display("FAIL cpu_wr_same_cycle: got %h want %h", cpu_rdata, exp_mem[15]);
        end
        step();
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL cpu_wr_next_cycle: got %h want a5", cpu_rdata);
        end
        exp_mem[15] = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            cpu_addr  = 4'($urandom_range(0, 3));
            cpu_we    = 1'($urandom);
            cpu_wdata = 8'($urandom);
            #1;
            n_tests++;
            if (cpu_rdata !== exp_mem[cpu_addr]) begin
                n_fail++;
                $display("FAIL cpu_b2b[%0d]: addr=%0d got %h want %h", i, cpu_addr, cpu_rdata, exp_mem[cpu_addr]);
            end
            if (cpu_we) exp_mem[cpu_addr] = cpu_wdata;
            step();
        end
        cpu_we = 1'b0;
        n_tests++;
        if (start !== 1'b1 || ld_count !== 5'(exp_k)) begin
            n_fail++;
            $display("FAIL cpu_run_hold: start=%b ld_count=%0d want 1 %0d", start, ld_count, exp_k);
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cpu_addr = 4'(a);
            #1;
            n_tests++;
            if (cpu_rdata !== exp_mem[a]) begin
                n_fail++;
                $display("FAIL cpu_mem[%0d]: got %h want %h", a, cpu_rdata, exp_mem[a]);
            end
        end
        step();
        reset     = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 4'hF;
        cpu_wdata = 8'h3C;
        step();
        reset  = 1'b1;
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (start !== 1'b0 || load_done !== 1'b0 || ld_ready !== 1'b1 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL run_reset: start=%b load_done=%b ld_ready=%b mem15=%h want 0 0 1 00",
                     start, load_done, ld_ready, cpu_rdata);
        end
    endtask

    task automatic test_load_cpu_ignored();
        do_reset();
        cpu_addr  = 4'hF;
        cpu_we    = 1'b1;
        cpu_wdata = 8'hA5;
        step();
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL load_cpu_we: got %h want 00", cpu_rdata);
        end
        cpu_addr  = 4'h8;
        cpu_we    = 1'b1;
        cpu_wdata = 8'h5A;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL load_cpu_we_accept: mem8=%h want 00", cpu_rdata);
        end
        cpu_addr = 4'h1;
        #1;
        n_tests++;
        if (cpu_rdata !== 8'h22 || ld_count !== 5'd2 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL load_partial: mem1=%h ld_count=%0d start=%b want 22 2 0", cpu_rdata, ld_count, start);
        end
    endtask

    task automatic test_mid_load_reset();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 1'b0);
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        ld_last  = 1'b1;
        step();
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        n_tests++;
        if (ld_count !== 5'd0 || ld_ready !== 1'b1 || start !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: ld_count=%0d ld_ready=%b start=%b load_done=%b want 0 1 0 0",
                     ld_count, ld_ready, start, load_done);
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cpu_addr = 4'(a);
            #1;
            n_tests++;
            if (cpu_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL midreset_mem[%0d]: got %h want 00", a, cpu_rdata);
            end
        end
        step();
        exp_k = 2;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_mem[0] = 8'hAB;
        exp_mem[1] = 8'hCD;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b1);
        finish_load();
        n_tests++;
        if (start !== 1'b1 || ld_count !== 5'd2) begin
            n_fail++;
            $display("FAIL reload_run: start=%b ld_count=%0d want 1 2", start, ld_count);
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cpu_addr = 4'(a);
            #1;
            n_tests++;
            if (cpu_rdata !== exp_mem[a]) begin
                n_fail++;
                $display("FAIL reload_mem[%0d]: got %h want %h", a, cpu_rdata, exp_mem[a]);
            end
        end
    endtask

`ifdef LOAD_CHECKSUM_EN
    task automatic test_checksum();
        step();
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        n_tests++;
        if (ld_ready !== 1'b1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL cksum_check_state: ld_ready=%b start=%b want 1 0", ld_ready, start);
        end
        send_byte(8'hFD, 1'b0);
        cpu_addr = 4'h2;
        #1;
        n_tests++;
        if (start !== 1'b1 || load_err !== 1'b0 || ld_count !== 5'd2 || cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL cksum_good: start=%b load_err=%b ld_count=%0d mem2=%h want 1 0 2 00",
                     start, load_err, ld_count, cpu_rdata);
        end
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b0);
        n_tests++;
        if (load_err !== 1'b1 || start !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cksum_bad: load_err=%b start=%b ld_ready=%b load_done=%b want 1 0 0 0",
                     load_err, start, ld_ready, load_done);
        end
        cpu_addr  = 4'h0;
        cpu_we    = 1'b1;
        cpu_wdata = 8'h77;
        step();
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_rdata !== 8'h01 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cpu_we: mem0=%h load_err=%b want 01 1", cpu_rdata, load_err);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_full_load();
        test_random_load();
        test_cpu_write();
        test_load_cpu_ignored();
        test_mid_load_reset();
`ifdef LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
